// File: rtl/vga_sync_gen.sv
// VGA timing generator. It divides the system clock into a pixel clock-enable
// and walks the horizontal and vertical counters through the active, front
// porch, sync and back porch regions. hs, vs and blank_n are registered on the
// same edge as DrawX/DrawY, so they always describe the coordinates shown in
// the same cycle.
// Optional feature: define VGA_SYNC_FRAME_COUNT_EN to build the 6-bit
// FrameCount register. Without it, FrameCount is tied to zero.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             pix_ce,
  output logic             hs,
  output logic             vs,
  output logic             blank_n,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             frame_start,
  output logic             line_end,
  output logic [5:0]       FrameCount
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  // Last coordinate of each region; a region change happens on the pix_ce
  // where the counter sits on one of these values.
  localparam logic [CNT_W-1:0] HActEnd  = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] HFpEnd   = CNT_W'(H_VISIBLE + H_FP - 1);
  localparam logic [CNT_W-1:0] HSyncEnd = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] HLast    = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VActEnd  = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] VFpEnd   = CNT_W'(V_VISIBLE + V_FP - 1);
  localparam logic [CNT_W-1:0] VSyncEnd = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] VLast    = CNT_W'(VTotal - 1);

  typedef enum logic [1:0] {HActive, HFront, HSync, HBack} h_state_e;
  typedef enum logic [1:0] {VActive, VFront, VSync, VBack} v_state_e;

  logic [DivW-1:0]  div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  h_state_e         h_state_q, h_state_d;
  v_state_e         v_state_q, v_state_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic             h_wrap;

  // Clock divider and the pulses decoded from the current registered state.
  always_comb begin
    div_d       = (div_q == DivLast) ? '0 : div_q + 1'b1;
    // Held low while Reset is asserted so CLK_DIV = 1 still shows the idle state.
    pix_ce      = (div_q == DivLast) & ~Reset;
    h_wrap      = (x_q == HLast);
    line_end    = pix_ce & h_wrap;
    frame_start = line_end & (y_q == VLast);
  end

  // Pixel and line counters; the V step and both wraps share the H wrap pulse.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_ce) begin
      x_d = h_wrap ? '0 : x_q + 1'b1;
      if (h_wrap) begin
        y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
      end
    end
  end

  // Horizontal region FSM, stepping on every pixel.
  always_comb begin
    h_state_d = h_state_q;
    if (pix_ce) begin
      unique case (h_state_q)
        HActive: if (x_q == HActEnd)  h_state_d = HFront;
        HFront:  if (x_q == HFpEnd)   h_state_d = HSync;
        HSync:   if (x_q == HSyncEnd) h_state_d = HBack;
        HBack:   if (x_q == HLast)    h_state_d = HActive;
        default: h_state_d = HActive;
      endcase
    end
  end

  // Vertical region FSM, stepping only at the end of each line.
  always_comb begin
    v_state_d = v_state_q;
    if (pix_ce && h_wrap) begin
      unique case (v_state_q)
        VActive: if (y_q == VActEnd)  v_state_d = VFront;
        VFront:  if (y_q == VFpEnd)   v_state_d = VSync;
        VSync:   if (y_q == VSyncEnd) v_state_d = VBack;
        VBack:   if (y_q == VLast)    v_state_d = VActive;
        default: v_state_d = VActive;
      endcase
    end
  end

  // Sync and blank decode from the next state so they land with the counters.
  always_comb begin
    hs_d      = (h_state_d != HSync);
    vs_d      = (v_state_d != VSync);
    blank_n_d = (h_state_d == HActive) && (v_state_d == VActive);
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      h_state_q <= HActive;
      v_state_q <= VActive;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b1;
    end else begin
      div_q     <= div_d;
      x_q       <= x_d;
      y_q       <= y_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign DrawX   = x_q;
  assign DrawY   = y_q;
  assign hs      = hs_q;
  assign vs      = vs_q;
  assign blank_n = blank_n_q;

`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [5:0] fc_q, fc_d;

  // Count vs falling edges: the line wrap that moves DrawY into the sync band.
  always_comb begin
    fc_d = fc_q;
    if (pix_ce && h_wrap && (y_q == VFpEnd)) begin
      fc_d = fc_q + 6'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign FrameCount = fc_q;
`else
  assign FrameCount = 6'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a reduced raster so many frames fit in a short
// run. The reference model derives every output from the number of clocks
// since the last reset: pixel index = completed pix_ce count modulo the frame
// size, and coordinates/sync/blank follow by plain arithmetic.
module tb_vga_sync_gen;

  localparam int unsigned CD    = 2;
  localparam int unsigned HV    = 8;
  localparam int unsigned HFP   = 2;
  localparam int unsigned HSW   = 3;
  localparam int unsigned HBP   = 2;
  localparam int unsigned VV    = 6;
  localparam int unsigned VFP   = 1;
  localparam int unsigned VSW   = 2;
  localparam int unsigned VBP   = 2;
  localparam int unsigned CW    = 5;
  localparam int unsigned HT    = HV + HFP + HSW + HBP;
  localparam int unsigned VT    = VV + VFP + VSW + VBP;
  localparam int unsigned FPIX  = HT * VT;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          pix_ce, hs, vs, blank_n, frame_start, line_end;
  logic [CW-1:0] DrawX, DrawY;
  logic [5:0]    FrameCount;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned k = 0;
  bit          m_hs, m_vs;

  vga_sync_gen #(
    .CLK_DIV  (CD),
    .H_VISIBLE(HV),
    .H_FP     (HFP),
    .H_SYNC   (HSW),
    .H_BP     (HBP),
    .V_VISIBLE(VV),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP),
    .CNT_W    (CW)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pix_ce     (pix_ce),
    .hs         (hs),
    .vs         (vs),
    .blank_n    (blank_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .frame_start(frame_start),
    .line_end   (line_end),
    .FrameCount (FrameCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, k);
    end
  endtask

  // Reference model evaluated for cycle k since the reset edge (reset cycle = 1).
  task automatic check_model(input bit rst);
    int unsigned p, n, x, y, fc;
    bit ce, bn, le, fs;
    ce   = !rst && (k % CD == 0);
    p    = (k - 1) / CD;
    n    = p % FPIX;
    x    = n % HT;
    y    = n / HT;
    m_hs = !(x >= HV + HFP && x < HV + HFP + HSW);
    m_vs = !(y >= VV + VFP && y < VV + VFP + VSW);
    bn   = (x < HV) && (y < VV);
    le   = ce && (x == HT - 1);
    fs   = le && (y == VT - 1);
`ifdef VGA_SYNC_FRAME_COUNT_EN
    fc = (p >= (VV + VFP) * HT) ? ((p - (VV + VFP) * HT) / FPIX + 1) % 64 : 0;
`else
    fc = 0;
`endif
    chk("pix_ce", 32'(pix_ce), 32'(ce));
    chk("DrawX", 32'(DrawX), x);
    chk("DrawY", 32'(DrawY), y);
    chk("hs", 32'(hs), 32'(m_hs));
    chk("vs", 32'(vs), 32'(m_vs));
    chk("blank_n", 32'(blank_n), 32'(bn));
    chk("line_end", 32'(line_end), 32'(le));
    chk("frame_start", 32'(frame_start), 32'(fs));
    chk("FrameCount", 32'(FrameCount), fc);
  endtask

  // One clock: drive Reset, take the edge, sample 1 ns later.
  task automatic step(input bit rst);
    Reset = rst;
    @(posedge Clk);
    #1;
    if (rst) k = 1;
    else k++;
    check_model(rst);
  endtask

  initial begin
    bit found;
    // Reset held for several cycles, then released.
    repeat (5) step(1'b1);
    // First pix_ce lands in the 2nd post-reset cycle; then run past the
    // 64-frame FrameCount wrap.
    repeat (70 * FPIX * CD) step(1'b0);

    // Reset while both syncs are active (mid-line, mid-vsync).
    found = 1'b0;
    for (int i = 0; i < 2 * FPIX * CD; i++) begin
      step(1'b0);
      if (!m_hs && !m_vs) begin
        found = 1'b1;
        break;
      end
    end
    chk("find_hs_vs_low", 32'(found), 32'd1);
    step(1'b1);
    repeat (3 * FPIX * CD) step(1'b0);

    // Random reset pulses sprinkled over free-running timing.
    repeat (6000) step($urandom_range(0, 199) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
